usd_range_filter: RTL and testbench
===================================

Name: usd_range_filter

Overview:
- Downstream consumer and scheduler for the ultrasonic distance sensor interface.
- Drives that interface's external trigger input periodically and samples its 16-bit microsecond response after each measurement window.
- Applies a 3-tap median filter, converts the result to centimetres, and produces an obstacle flag with hysteresis for the navigation logic.

Parameters:
- PERIOD_CLKS, 3000000, clocks per measurement cycle, measured from trigger rise (60 ms at 50 MHz); must be > TRIG_HOLD_CLKS + 8.
- TRIG_HOLD_CLKS, 1100000, clocks the trigger is held high (22 ms); covers the sensor's worst-case timeouts of about 20 ms.
- NEAR_CM, 20, obstacle asserts when filtered cm < NEAR_CM.
- FAR_CM, 30, obstacle clears when filtered cm > FAR_CM; must be > NEAR_CM.

Ports:
- clk_50mhz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when high, new measurement cycles may start.
- sensor_response  in  16  distance in us from the sensor interface; 16'h2709 and 16'h2710 are timeout codes.
- sensor_trigger_req  out  1  connects to the sensor interface's trigger input.
- distance_cm  out  8  filtered distance in cm; 8'hFF means no echo or out of range.
- distance_valid  out  1  one-cycle pulse when distance_cm and obstacle update.
- obstacle  out  1  hysteretic near-obstacle flag.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async) values: sensor_trigger_req=0, distance_cm=8'hFF, distance_valid=0, obstacle=0, busy=0, state=IDLE, counter=0. All three history entries = 10000.
- Reset mid-cycle: the trigger drops immediately and no partial sample is used.
- FSM states: IDLE, HOLD, SAMPLE, FILTER, CONVERT, OUTPUT, WAIT.
- IDLE:
  - If enable=1: trigger <= 1, counter <= 0, go to HOLD.
  - Otherwise stay in IDLE.
- HOLD:
  - counter increments each cycle.
  - At counter == TRIG_HOLD_CLKS-1: trigger <= 0, go to SAMPLE.
  - The trigger is therefore high for exactly TRIG_HOLD_CLKS cycles.
- SAMPLE (first cycle with the trigger low):
  - Register sensor_response.
  - Clamp: any value >= 9993 (16'h2709) becomes 10000.
  - Shift into history: h2 <= h1, h1 <= h0, h0 <= clamped value.
- FILTER:
  - Compute the median of h0, h1, h2 with pairwise compares.
  - Ties resolve to the equal value.
  - Register the 16-bit result.
- CONVERT:
  - If median == 10000: cm = 255.
  - Else: cm = (median * 1130) >> 16, using a 27-bit product, saturated to 255.
- OUTPUT:
  - distance_cm <= cm; distance_valid <= 1 for exactly one cycle.
  - obstacle: set if cm < NEAR_CM; clear if cm > FAR_CM; otherwise hold.
  - Go to WAIT.
- WAIT:
  - counter keeps incrementing.
  - At counter == PERIOD_CLKS-1: go to IDLE, where the next cycle starts immediately if enable=1.
  - Trigger rise-to-rise spacing is PERIOD_CLKS+1 cycles.
- Latency: distance_valid is high in the 4th cycle after the trigger falls, counting the SAMPLE cycle as the 1st.
- enable dropping mid-cycle: the current cycle completes, including its output update, then the FSM parks in IDLE.
- The counter runs through HOLD, SAMPLE, FILTER, CONVERT, OUTPUT and WAIT; it never wraps within a cycle.
- Warm-up: because history resets to 10000, the first valid echo produces a median of 10000 (cm=255). The second consecutive equal echo produces the real value.
- sensor_response is only sampled in SAMPLE; changes at other times are ignored.

Test Plan:
- Reset, enable=1, sensor_response=580 constant:
  - Trigger high exactly 1100000 cycles.
  - First valid pulse gives distance_cm=255, obstacle=0.
  - Second gives distance_cm=10, obstacle=1.
- Steady 580 after warm-up, then a single sample of 16'h2710, then 580:
  - distance_cm stays 10 and obstacle stays 1 throughout (spike rejected).
- Obstacle set, then responses 1160 (20 cm) x3:
  - obstacle stays 1.
- Then 2900 (50 cm) x2:
  - obstacle clears on the second 2900 sample's valid pulse.
- enable=0 asserted midway through HOLD:
  - The trigger still completes its full hold and exactly one valid pulse follows.
  - No further trigger rises; busy=0 after WAIT ends.
- Async reset asserted during WAIT with obstacle=1:
  - All outputs return to their reset values without a clock edge.
  - After release with enable=1, the next trigger rise occurs on the first clock edge.

Source files
------------

// File: rtl/usd_range_filter_if.sv
// Bus between the ultrasonic range filter and its environment.
// Handshake: distance_valid is a one-cycle strobe with no ready; distance_cm and obstacle are stable from it until the next strobe.
interface usd_range_filter_if;
   logic        enable;
   logic [15:0] sensor_response;
   logic        sensor_trigger_req;
   logic [7:0]  distance_cm;
   logic        distance_valid;
   logic        obstacle;
   logic        busy;
   logic [2:0]  state;

   modport master (
      output enable, sensor_response,
      input  sensor_trigger_req, distance_cm, distance_valid, obstacle, busy, state
   );

   modport slave (
      input  enable, sensor_response,
      output sensor_trigger_req, distance_cm, distance_valid, obstacle, busy, state
   );
endinterface

// File: rtl/usd_range_filter.sv
// Schedules ultrasonic measurements, median-filters the microsecond response,
// converts to centimetres and derives a hysteretic obstacle flag.
module usd_range_filter #(
   parameter int PERIOD_CLKS    = 3000000,
   parameter int TRIG_HOLD_CLKS = 1100000,
   parameter int NEAR_CM        = 20,
   parameter int FAR_CM         = 30
) (
   input  logic              clk_50mhz,
   input  logic              reset,
   usd_range_filter_if.slave bus
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] HOLD    = 3'd1;
   localparam logic [2:0] SAMPLE  = 3'd2;
   localparam logic [2:0] FILTER  = 3'd3;
   localparam logic [2:0] CONVERT = 3'd4;
   localparam logic [2:0] OUTPUT  = 3'd5;
   localparam logic [2:0] WAIT    = 3'd6;

   localparam int          CW         = $clog2(PERIOD_CLKS + 1);
   localparam logic [CW-1:0] HOLD_LAST   = CW'(TRIG_HOLD_CLKS - 1);
   localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD_CLKS - 1);
   localparam logic [15:0] NO_ECHO    = 16'd10000;
   localparam logic [15:0] CLAMP_MIN  = 16'd9993;

   logic [2:0]    state;
   logic [CW-1:0] counter;
   logic          trig;
   logic [15:0]   h0, h1, h2;
   logic [15:0]   median_q;
   logic [7:0]    dist_q;
   logic          valid_q;
   logic          obst_q;

   logic [15:0] clamped;
   logic [15:0] lo01, hi01, median;
   logic [26:0] product;
   logic [10:0] cm_wide;
   logic [7:0]  cm;

   always_comb begin
      clamped = (bus.sensor_response >= CLAMP_MIN) ? NO_ECHO : bus.sensor_response;
      lo01    = (h0 < h1) ? h0 : h1;
      hi01    = (h0 < h1) ? h1 : h0;
      // median = clamp h2 into [min(h0,h1), max(h0,h1)]; ties land on the equal value
      if (h2 <= lo01)
         median = lo01;
      else if (h2 >= hi01)
         median = hi01;
      else
         median = h2;
      product = 27'(median_q) * 27'd1130;
      cm_wide = 11'(product >> 16);
      if (median_q == NO_ECHO)
         cm = 8'hFF;
      else if (cm_wide > 11'd255)
         cm = 8'hFF;
      else
         cm = cm_wide[7:0];
   end

   always_ff @(posedge clk_50mhz or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         counter  <= '0;
         trig     <= 1'b0;
         h0       <= NO_ECHO;
         h1       <= NO_ECHO;
         h2       <= NO_ECHO;
         median_q <= NO_ECHO;
         dist_q   <= 8'hFF;
         valid_q  <= 1'b0;
         obst_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.enable) begin
                  trig    <= 1'b1;
                  counter <= '0;
                  state   <= HOLD;
               end
            end
            HOLD: begin
               counter <= counter + CW'(1);
               if (counter == HOLD_LAST) begin
                  trig  <= 1'b0;
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               counter <= counter + CW'(1);
               h2      <= h1;
               h1      <= h0;
               h0      <= clamped;
               state   <= FILTER;
            end
            FILTER: begin
               counter  <= counter + CW'(1);
               median_q <= median;
               state    <= CONVERT;
            end
            CONVERT: begin
               // Results load on this edge so they are visible, with the strobe, throughout OUTPUT.
               counter <= counter + CW'(1);
               dist_q  <= cm;
               valid_q <= 1'b1;
               if (cm < 8'(NEAR_CM))
                  obst_q <= 1'b1;
               else if (cm > 8'(FAR_CM))
                  obst_q <= 1'b0;
               state <= OUTPUT;
            end
            OUTPUT: begin
               counter <= counter + CW'(1);
               state   <= WAIT;
            end
            WAIT: begin
               counter <= counter + CW'(1);
               if (counter == PERIOD_LAST)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sensor_trigger_req = trig;
   assign bus.distance_cm        = dist_q;
   assign bus.distance_valid     = valid_q;
   assign bus.obstacle           = obst_q;
   assign bus.busy               = (state != IDLE);
   assign bus.state              = state;
endmodule

// File: tb/tb_usd_range_filter.sv
// Directed bench for usd_range_filter with shortened hold/period so the
// full warm-up, spike, hysteresis, enable-drop and async-reset sequence runs quickly.
module tb_usd_range_filter;
   localparam int PERIOD = 30;
   localparam int HOLD   = 10;
   localparam int LIMIT  = 200;

   logic clk_50mhz = 1'b0;
   logic reset     = 1'b1;
   always #5 clk_50mhz = ~clk_50mhz;

   usd_range_filter_if bus ();

   usd_range_filter #(
      .PERIOD_CLKS   (PERIOD),
      .TRIG_HOLD_CLKS(HOLD),
      .NEAR_CM       (20),
      .FAR_CM        (30)
   ) dut (
      .clk_50mhz(clk_50mhz),
      .reset    (reset),
      .bus      (bus)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;
   int cyc       = 0;

   always @(posedge clk_50mhz) cyc++;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total_cnt++;
      assert (observed === expected) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Called at a negedge; runs one measurement cycle and captures its result.
   task automatic run_cycle(input logic [15:0] resp, input int drop_after,
                            output int trig_len, output int lat, output int rise_cyc,
                            output logic [7:0] cm, output logic obs,
                            output logic valid_next, output logic to);
      int n;
      to = 1'b0; trig_len = 0; lat = 0; rise_cyc = 0;
      cm = 8'h00; obs = 1'b0; valid_next = 1'b1;
      bus.sensor_response = resp;
      n = 0;
      while (!bus.sensor_trigger_req && n < LIMIT) begin
         @(negedge clk_50mhz);
         n++;
      end
      if (n >= LIMIT) begin
         to = 1'b1;
         return;
      end
      rise_cyc = cyc;
      while (bus.sensor_trigger_req && trig_len < LIMIT) begin
         trig_len++;
         if (trig_len == drop_after) bus.enable = 1'b0;
         @(negedge clk_50mhz);
      end
      lat = 1;
      while (!bus.distance_valid && lat < LIMIT) begin
         @(negedge clk_50mhz);
         lat++;
      end
      if (lat >= LIMIT) begin
         to = 1'b1;
         return;
      end
      cm  = bus.distance_cm;
      obs = bus.obstacle;
      @(negedge clk_50mhz);
      valid_next = bus.distance_valid;
   endtask

   logic [15:0] tbl_resp[8] = '{16'd580, 16'h2710, 16'd580, 16'd1160, 16'd1160, 16'd1160, 16'd2900, 16'd2900};
   logic [7:0]  tbl_cm[8]   = '{8'd10, 8'd10, 8'd10, 8'd20, 8'd20, 8'd20, 8'd20, 8'd50};
   logic        tbl_obs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      int tl, lt, rc, rise1, rises;
      logic [7:0] cm;
      logic obs, vn, to;

      bus.enable = 1'b0;
      bus.sensor_response = 16'd0;
      repeat (3) @(negedge clk_50mhz);
      check("rst_trig", bus.sensor_trigger_req, 0);
      check("rst_cm", bus.distance_cm, 8'hFF);
      check("rst_valid", bus.distance_valid, 0);
      check("rst_obst", bus.obstacle, 0);
      check("rst_busy", bus.busy, 0);

      // warm-up: first echo still sees two no-echo history entries
      bus.enable = 1'b1;
      reset = 1'b0;
      run_cycle(16'd580, 0, tl, lt, rc, cm, obs, vn, to);
      rise1 = rc;
      check("c1_timeout", to, 0);
      check("c1_trig_len", tl, HOLD);
      check("c1_latency", lt, 4);
      check("c1_cm", cm, 8'hFF);
      check("c1_obst", obs, 0);
      check("c1_pulse_width", vn, 0);

      run_cycle(16'd580, 0, tl, lt, rc, cm, obs, vn, to);
      check("c2_timeout", to, 0);
      check("c2_spacing", rc - rise1, PERIOD + 1);
      check("c2_cm", cm, 8'd10);
      check("c2_obst", obs, 1);

      // spike rejection, then hysteresis band, then clear above FAR
      for (int i = 0; i < 8; i++) begin
         run_cycle(tbl_resp[i], 0, tl, lt, rc, cm, obs, vn, to);
         check($sformatf("tbl%0d_timeout", i), to, 0);
         check($sformatf("tbl%0d_cm", i), cm, tbl_cm[i]);
         check($sformatf("tbl%0d_obst", i), obs, tbl_obs[i]);
      end

      // enable drops during HOLD: cycle completes, then parks
      run_cycle(16'd2900, 3, tl, lt, rc, cm, obs, vn, to);
      check("drop_timeout", to, 0);
      check("drop_trig_len", tl, HOLD);
      check("drop_cm", cm, 8'd50);
      rises = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_50mhz);
         if (bus.sensor_trigger_req) rises++;
      end
      check("drop_no_retrigger", rises, 0);
      check("drop_busy", bus.busy, 0);
      check("drop_state", bus.state, 0);

      // build up obstacle=1 again, then reset asynchronously during WAIT
      bus.enable = 1'b1;
      run_cycle(16'd580, 0, tl, lt, rc, cm, obs, vn, to);
      check("re1_cm", cm, 8'd50);
      run_cycle(16'd580, 0, tl, lt, rc, cm, obs, vn, to);
      check("re2_cm", cm, 8'd10);
      check("re2_obst", obs, 1);
      repeat (3) @(negedge clk_50mhz);
      check("wait_busy", bus.busy, 1);
      check("wait_obst", bus.obstacle, 1);
      #1 reset = 1'b1;
      #1;
      check("arst_trig", bus.sensor_trigger_req, 0);
      check("arst_cm", bus.distance_cm, 8'hFF);
      check("arst_valid", bus.distance_valid, 0);
      check("arst_obst", bus.obstacle, 0);
      check("arst_busy", bus.busy, 0);
      @(negedge clk_50mhz);
      reset = 1'b0;
      @(negedge clk_50mhz);
      check("rel_trig_first_edge", bus.sensor_trigger_req, 1);
      run_cycle(16'd580, 0, tl, lt, rc, cm, obs, vn, to);
      check("rel_timeout", to, 0);
      check("rel_trig_len", tl, HOLD);
      check("rel_cm_warmup", cm, 8'hFF);
      check("rel_obst", obs, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
